counter_updown_mod: RTL and testbench

Parametrised successor to the team's loadable up-counter. Counts up or down within the range 0..limit and supports parallel load and count enable. Three boundary modes are selectable at runtime: wrap, saturate and one-shot. Outputs a registered terminal-count pulse and a sticky done flag, for use as a timer or event divider in control paths.

---
 rtl/counter_pkg.sv | 14 +
 rtl/counter_updown_mod_if.sv | 48 ++++
 rtl/counter_prescaler.sv | 29 ++
 rtl/counter_updown_mod.sv | 86 ++++++++
 tb/tb_counter_updown_mod.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter: boundary-mode encodings.
// Optional prescaler build is selected with COUNTER_PRESCALE_EN.
package counter_pkg;

    localparam int MODE_W = 2;

    typedef logic [MODE_W-1:0] mode_t;

    localparam mode_t MODE_WRAP    = 2'd0;
    localparam mode_t MODE_SAT     = 2'd1;
    localparam mode_t MODE_ONESHOT = 2'd2;
    // 2'd3 is reserved and decodes as wrap

endpackage

// File: rtl/counter_updown_mod_if.sv
// Control/status bundle for counter_updown_mod.
// presc_div only exists when COUNTER_PRESCALE_EN is defined.
interface counter_updown_mod_if
    import counter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 4
);

    logic             en;
    logic             load;
    logic [WIDTH-1:0] data_load;
    logic             up;
    mode_t            mode;
    logic [WIDTH-1:0] limit;
`ifdef COUNTER_PRESCALE_EN
    logic [PRESC_W-1:0] presc_div;
`else
    // keep the parameter referenced so both builds share one interface signature
    if (PRESC_W < 1) begin : g_presc_w_unused
    end
`endif
    logic             at_bound;
    logic [WIDTH-1:0] cnt;
    logic             tc;
    logic             done;

`ifdef COUNTER_PRESCALE_EN
    modport master (
        output en, load, data_load, up, mode, limit, presc_div,
        input  cnt, tc, done, at_bound
    );
    modport slave (
        input  en, load, data_load, up, mode, limit, presc_div,
        output cnt, tc, done, at_bound
    );
`else
    modport master (
        output en, load, data_load, up, mode, limit,
        input  cnt, tc, done, at_bound
    );
    modport slave (
        input  en, load, data_load, up, mode, limit,
        output cnt, tc, done, at_bound
    );
`endif

endinterface

// File: rtl/counter_prescaler.sv
// Divides qualified advance cycles: tick on every (div+1)-th adv cycle.
// Used by counter_updown_mod only when COUNTER_PRESCALE_EN is defined.
module counter_prescaler #(
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               adv,
    input  logic [PRESC_W-1:0] div,
    output logic               tick
);

    logic [PRESC_W-1:0] pcnt;

    // >= rather than == so a div lowered below the running count rolls over at once
    assign tick = adv && (pcnt >= div);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt <= '0;
        end else if (clr) begin
            pcnt <= '0;
        end else if (adv) begin
            pcnt <= tick ? '0 : pcnt + 1'b1;
        end
    end

endmodule

// File: rtl/counter_updown_mod.sv
// Up/down counter over 0..limit with load, wrap/sat/one-shot boundary modes,
// registered tc pulse and sticky done. COUNTER_PRESCALE_EN adds a step prescaler.
module counter_updown_mod
    import counter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    counter_updown_mod_if.slave   bus
);

    logic [WIDTH-1:0] cnt_q, cnt_nxt;
    logic             tc_q, tc_nxt;
    logic             done_q, done_nxt;
    logic             at_bound;
    logic             tick;
    logic             step;

    function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] val,
                                               input logic [WIDTH-1:0] lim);
        return (val > lim) ? lim : val;
    endfunction

    // cnt above a freshly lowered limit counts as the upper bound
    assign at_bound = (bus.up && (cnt_q >= bus.limit)) || (!bus.up && (cnt_q == '0));

`ifdef COUNTER_PRESCALE_EN
    counter_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk  (clk),
        .rst  (rst),
        .clr  (bus.load),
        .adv  (bus.en && !done_q && !bus.load),
        .div  (bus.presc_div),
        .tick (tick)
    );
`else
    assign tick = 1'b1;
    if (PRESC_W < 1) begin : g_presc_w_unused
    end
`endif

    assign step = bus.en && !bus.load && !done_q && tick;

    always_comb begin
        cnt_nxt  = cnt_q;
        tc_nxt   = 1'b0;
        done_nxt = done_q;
        if (bus.load) begin
            cnt_nxt  = clamp(bus.data_load, bus.limit);
            done_nxt = 1'b0;
        end else if (step) begin
            tc_nxt = at_bound;
            if (!at_bound) begin
                cnt_nxt = bus.up ? cnt_q + 1'b1 : cnt_q - 1'b1;
            end else begin
                case (bus.mode)
                    MODE_SAT:     cnt_nxt = cnt_q;
                    MODE_ONESHOT: done_nxt = 1'b1;
                    default:      cnt_nxt = bus.up ? '0 : bus.limit;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            tc_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_nxt;
            tc_q   <= tc_nxt;
            done_q <= done_nxt;
        end
    end

    assign bus.cnt      = cnt_q;
    assign bus.tc       = tc_q;
    assign bus.done     = done_q;
    assign bus.at_bound = at_bound;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Table-driven bench for counter_updown_mod with an expected-result queue.
// Prescaler sequence runs only when COUNTER_PRESCALE_EN is defined.
module tb_counter_updown_mod;
    import counter_pkg::*;

    localparam int W  = 8;
    localparam int PW = 4;

    typedef struct {
        logic         en;
        logic         ld;
        logic [W-1:0] dl;
        logic         up;
        mode_t        md;
        logic [W-1:0] lim;
        logic         ab;
        logic [W-1:0] cnt;
        logic         tc;
        logic         done;
    } vec_t;

    typedef struct {
        logic [W-1:0] cnt;
        logic         tc;
        logic         done;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;
    vec_t tbl[$];
    exp_t sb[$];

    counter_updown_mod_if #(.WIDTH(W), .PRESC_W(PW)) bus ();

    counter_updown_mod #(.WIDTH(W), .PRESC_W(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input bit en, input bit ld, input int dl, input bit up,
                                input int md, input int lim, input bit ab, input int c,
                                input bit tc, input bit dn);
        vec_t v;
        v.en = en; v.ld = ld; v.dl = dl[W-1:0]; v.up = up; v.md = md[1:0];
        v.lim = lim[W-1:0]; v.ab = ab; v.cnt = c[W-1:0]; v.tc = tc; v.done = dn;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // drive one cycle of stimulus, queue its post-edge expectation, then retire it
    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        bus.en = v.en; bus.load = v.ld; bus.data_load = v.dl;
        bus.up = v.up; bus.mode = v.md; bus.limit = v.lim;
        #1;
        chk($sformatf("at_bound[%0d]", idx), int'(bus.at_bound), int'(v.ab));
        sb.push_back('{cnt: v.cnt, tc: v.tc, done: v.done});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk($sformatf("sb_empty[%0d]", idx), 1, 0);
        end else begin
            e = sb.pop_front();
            chk($sformatf("cnt[%0d]", idx),  int'(bus.cnt),  int'(e.cnt));
            chk($sformatf("tc[%0d]", idx),   int'(bus.tc),   int'(e.tc));
            chk($sformatf("done[%0d]", idx), int'(bus.done), int'(e.done));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.en = 1'b0; bus.load = 1'b0; bus.data_load = '0;
        bus.up = 1'b1; bus.mode = MODE_WRAP; bus.limit = '0;
`ifdef COUNTER_PRESCALE_EN
        bus.presc_div = '0;
`endif
        // en ld dl up md lim | ab cnt tc done
        tbl.push_back(mk(1,0,0,1,0,5, 0,1,0,0));
        tbl.push_back(mk(1,0,0,1,0,5, 0,2,0,0));
        tbl.push_back(mk(1,0,0,1,0,5, 0,3,0,0));
        tbl.push_back(mk(1,0,0,1,0,5, 0,4,0,0));
        tbl.push_back(mk(1,0,0,1,0,5, 0,5,0,0));
        tbl.push_back(mk(1,0,0,1,0,5, 1,0,1,0));
        tbl.push_back(mk(1,0,0,1,0,5, 0,1,0,0));
        tbl.push_back(mk(1,1,2,0,0,5, 0,2,0,0));
        tbl.push_back(mk(1,0,0,0,0,5, 0,1,0,0));
        tbl.push_back(mk(1,0,0,0,0,5, 0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,5, 1,5,1,0));
        tbl.push_back(mk(1,0,0,0,0,5, 0,4,0,0));
        tbl.push_back(mk(1,1,3,1,1,4, 1,3,0,0));
        tbl.push_back(mk(1,0,0,1,1,4, 0,4,0,0));
        tbl.push_back(mk(1,0,0,1,1,4, 1,4,1,0));
        tbl.push_back(mk(1,0,0,1,1,4, 1,4,1,0));
        tbl.push_back(mk(0,0,0,1,1,4, 1,4,0,0));
        tbl.push_back(mk(1,1,3,0,2,9, 0,3,0,0));
        tbl.push_back(mk(1,0,0,0,2,9, 0,2,0,0));
        tbl.push_back(mk(1,0,0,0,2,9, 0,1,0,0));
        tbl.push_back(mk(1,0,0,0,2,9, 0,0,0,0));
        tbl.push_back(mk(1,0,0,0,2,9, 1,0,1,1));
        tbl.push_back(mk(1,0,0,0,2,9, 1,0,0,1));
        tbl.push_back(mk(1,0,0,1,2,9, 0,0,0,1));
        tbl.push_back(mk(1,0,0,1,0,9, 0,0,0,1));
        tbl.push_back(mk(1,1,7,1,2,9, 0,7,0,0));
        tbl.push_back(mk(1,0,0,1,2,9, 0,8,0,0));
        tbl.push_back(mk(1,1,200,1,0,10, 0,10,0,0));
        tbl.push_back(mk(1,0,0,1,0,10, 1,0,1,0));
        tbl.push_back(mk(1,1,8,1,0,10, 0,8,0,0));
        tbl.push_back(mk(1,0,0,1,1,5, 1,8,1,0));
        tbl.push_back(mk(1,0,0,1,0,5, 1,0,1,0));
        tbl.push_back(mk(1,1,9,1,0,10, 0,9,0,0));
        tbl.push_back(mk(1,0,0,0,0,5, 0,8,0,0));
        tbl.push_back(mk(1,0,0,1,0,0, 1,0,1,0));
        tbl.push_back(mk(1,0,0,1,0,0, 1,0,1,0));
        tbl.push_back(mk(0,0,0,1,0,0, 1,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0, 1,0,1,0));
        tbl.push_back(mk(1,1,4,1,3,5, 0,4,0,0));
        tbl.push_back(mk(1,0,0,1,3,5, 0,5,0,0));
        tbl.push_back(mk(1,0,0,1,3,5, 1,0,1,0));

        #3;
        chk("reset_cnt",  int'(bus.cnt),  0);
        chk("reset_tc",   int'(bus.tc),   0);
        chk("reset_done", int'(bus.done), 0);
        #9 rst = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) apply(tbl[i], i);

        // reach cnt=6 with tc and done set, then reset asynchronously mid-cycle
        apply(mk(1,1,5,1,2,6, 0,5,0,0), 100);
        apply(mk(1,0,0,1,2,6, 0,6,0,0), 101);
        apply(mk(1,0,0,1,2,6, 1,6,1,1), 102);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_cnt",  int'(bus.cnt),  0);
        chk("async_rst_tc",   int'(bus.tc),   0);
        chk("async_rst_done", int'(bus.done), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

`ifdef COUNTER_PRESCALE_EN
        bus.presc_div = 4'd2;
        apply(mk(1,1,0,1,0,3, 0,0,0,0), 200);
        apply(mk(1,0,0,1,0,3, 0,0,0,0), 201);
        apply(mk(1,0,0,1,0,3, 0,0,0,0), 202);
        apply(mk(1,0,0,1,0,3, 0,1,0,0), 203);
        apply(mk(1,0,0,1,0,3, 0,1,0,0), 204);
        // load one cycle into the interval: spacing restarts from the load
        apply(mk(1,1,1,1,0,3, 0,1,0,0), 205);
        apply(mk(1,0,0,1,0,3, 0,1,0,0), 206);
        apply(mk(1,0,0,1,0,3, 0,1,0,0), 207);
        apply(mk(1,0,0,1,0,3, 0,2,0,0), 208);
        bus.presc_div = 4'd0;
        apply(mk(1,0,0,1,0,3, 0,3,0,0), 209);
        apply(mk(1,0,0,1,0,3, 1,0,1,0), 210);
`endif

        if (sb.size() != 0) chk("sb_leftover", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
